// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer: Moore FSM stepping fetch/decode/execute and
// driving datapath load enables, bus gates, mux selects and SRAM enables.
module lc3_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       MIO_EN,
    output logic       Mem_OE_n,
    output logic       Mem_WE_n
);

    localparam int CW = $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);
    localparam logic [CW-1:0] LED_ARM   = CW'(1);

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH, S_RD_IF, S_LOAD_IR, S_DECODE, S_EX_ALU,
        S_BR, S_BR_TAKE, S_JMP, S_JSR_LINK, S_JSR_JUMP,
        S_LDR_ADDR, S_RD_LDR, S_LDR_WB, S_STR_ADDR, S_STR_DATA, S_WR,
        S_PAUSE_1, S_PAUSE_2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // cnt is a down-counter for memory waits; in PAUSE_1 it flags the entry cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_HALTED;
            cnt   <= '0;
        end else begin
            case (state)
                S_HALTED:   if (Run) state <= S_FETCH;
                S_FETCH: begin
                    state <= S_RD_IF;
                    cnt   <= WAIT_LAST;
                end
                S_RD_IF: begin
                    if (cnt == '0) state <= S_LOAD_IR;
                    else           cnt   <= cnt - 1'b1;
                end
                S_LOAD_IR:  state <= S_DECODE;
                S_DECODE: begin
                    case (Opcode)
                        4'b0001, 4'b0101, 4'b1001: state <= S_EX_ALU;
                        4'b0000: state <= S_BR;
                        4'b1100: state <= S_JMP;
                        4'b0100: state <= S_JSR_LINK;
                        4'b0110: state <= S_LDR_ADDR;
                        4'b0111: state <= S_STR_ADDR;
                        4'b1101: begin
                            state <= S_PAUSE_1;
                            cnt   <= LED_ARM;
                        end
                        default: state <= S_FETCH;
                    endcase
                end
                S_EX_ALU:   state <= S_FETCH;
                S_BR:       state <= BEN ? S_BR_TAKE : S_FETCH;
                S_BR_TAKE:  state <= S_FETCH;
                S_JMP:      state <= S_FETCH;
                S_JSR_LINK: state <= S_JSR_JUMP;
                S_JSR_JUMP: state <= S_FETCH;
                S_LDR_ADDR: begin
                    state <= S_RD_LDR;
                    cnt   <= WAIT_LAST;
                end
                S_RD_LDR: begin
                    if (cnt == '0) state <= S_LDR_WB;
                    else           cnt   <= cnt - 1'b1;
                end
                S_LDR_WB:   state <= S_FETCH;
                S_STR_ADDR: state <= S_STR_DATA;
                S_STR_DATA: begin
                    state <= S_WR;
                    cnt   <= WAIT_LAST;
                end
                S_WR: begin
                    if (cnt == '0) state <= S_FETCH;
                    else           cnt   <= cnt - 1'b1;
                end
                S_PAUSE_1: begin
                    cnt <= '0;
                    if (Continue) state <= S_PAUSE_2;
                end
                S_PAUSE_2:  if (!Continue) state <= S_FETCH;
                default:    state <= S_HALTED;
            endcase
        end
    end

    always_comb begin
        LD_MAR = 1'b0;  LD_MDR = 1'b0;  LD_IR = 1'b0;   LD_BEN = 1'b0;
        LD_CC = 1'b0;   LD_REG = 1'b0;  LD_PC = 1'b0;   LD_LED = 1'b0;
        GatePC = 1'b0;  GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00;  ADDR2MUX = 2'b00; ALUK = 2'b00;
        DRMUX = 1'b0;   SR1MUX = 1'b0;  SR2MUX = 1'b0;  ADDR1MUX = 1'b0;
        MIO_EN = 1'b0;  Mem_OE_n = 1'b1; Mem_WE_n = 1'b1;
        case (state)
            S_FETCH: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            S_RD_IF, S_RD_LDR: begin
                Mem_OE_n = 1'b0;
                MIO_EN   = 1'b1;
                LD_MDR   = (cnt == '0);
            end
            S_LOAD_IR: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE:   LD_BEN = 1'b1;
            S_EX_ALU: begin
                SR2MUX  = IR_5;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                case (Opcode)
                    4'b0101: ALUK = 2'b01;
                    4'b1001: ALUK = 2'b10;
                    default: ALUK = 2'b00;
                endcase
            end
            S_BR_TAKE: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
            end
            S_JMP: begin
                PCMUX = 2'b01;
                LD_PC = 1'b1;
            end
            S_JSR_LINK: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            S_JSR_JUMP: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
            end
            S_LDR_ADDR, S_STR_ADDR: begin
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S_LDR_WB: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_STR_DATA: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S_WR:       Mem_WE_n = 1'b0;
            S_PAUSE_1:  LD_LED = (cnt == LED_ARM);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Random-instruction bench for lc3_control_fsm at MEM_WAIT=2 and MEM_WAIT=3;
// expected per-cycle control words are built from the instruction timing rules.
`timescale 1ns/1ps
module tb_lc3_control_fsm;

    localparam int W0 = 2;
    localparam int W1 = 3;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic drmux, sr1mux, sr2mux, addr1mux, mio_en, oe_n, we_n;
    } ctl_t;

    // cont: 0/1 = Continue forced to that value, 2 = don't care (randomised)
    typedef struct {
        ctl_t c;
        int   cont;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n  [2];
    logic       run    [2];
    logic       cont   [2];
    logic [3:0] opcode [2];
    logic       ir_5   [2];
    logic       ben    [2];
    ctl_t       obs    [2];

    int    tests = 0;
    int    fails = 0;
    step_t q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W = (g == 0) ? W0 : W1;
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic drmux, sr1mux, sr2mux, addr1mux, mio_en, oe_n, we_n;

        lc3_control_fsm #(.MEM_WAIT(W)) dut (
            .Clk(clk), .Reset_n(rst_n[g]), .Run(run[g]), .Continue(cont[g]),
            .Opcode(opcode[g]), .IR_5(ir_5[g]), .BEN(ben[g]),
            .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
            .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
            .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu),
            .GateMARMUX(gate_marmux), .PCMUX(pcmux), .ADDR2MUX(addr2mux),
            .ALUK(aluk), .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux),
            .ADDR1MUX(addr1mux), .MIO_EN(mio_en), .Mem_OE_n(oe_n), .Mem_WE_n(we_n)
        );

        assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                         gate_pc, gate_mdr, gate_alu, gate_marmux,
                         pcmux, addr2mux, aluk,
                         drmux, sr1mux, sr2mux, addr1mux, mio_en, oe_n, we_n};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int idx);
        return (idx == 0) ? W0 : W1;
    endfunction

    function automatic ctl_t dflt();
        ctl_t c;
        c      = '0;
        c.oe_n = 1'b1;
        c.we_n = 1'b1;
        return c;
    endfunction

    task automatic push(input ctl_t c, input int cv);
        step_t s;
        s.c    = c;
        s.cont = cv;
        q.push_back(s);
    endtask

    task automatic add_mem(input int w, input bit write);
        ctl_t c;
        for (int i = 0; i < w; i++) begin
            c = dflt();
            if (write) begin
                c.we_n = 1'b0;
            end else begin
                c.oe_n   = 1'b0;
                c.mio_en = 1'b1;
                c.ld_mdr = (i == w - 1);
            end
            push(c, 2);
        end
    endtask

    // Expected control-word trace of one instruction, from FETCH up to (not
    // including) the next FETCH.
    task automatic build_instr(input int w, input logic [3:0] op, input logic ir5,
                               input logic bn, input int n0, input int n1);
        ctl_t c;
        q.delete();
        c = dflt(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push(c, 2);
        add_mem(w, 1'b0);
        c = dflt(); c.gate_mdr = 1; c.ld_ir = 1; push(c, 2);
        c = dflt(); c.ld_ben = 1; push(c, 2);
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                c = dflt(); c.sr2mux = ir5; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
                c.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
                push(c, 2);
            end
            4'b0000: begin
                push(dflt(), 2);
                if (bn) begin
                    c = dflt(); c.addr1mux = 1; c.addr2mux = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1;
                    push(c, 2);
                end
            end
            4'b1100: begin
                c = dflt(); c.pcmux = 2'b01; c.ld_pc = 1; push(c, 2);
            end
            4'b0100: begin
                c = dflt(); c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; push(c, 2);
                c = dflt(); c.addr1mux = 1; c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1;
                push(c, 2);
            end
            4'b0110: begin
                c = dflt(); c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1; push(c, 2);
                add_mem(w, 1'b0);
                c = dflt(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push(c, 2);
            end
            4'b0111: begin
                c = dflt(); c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1; push(c, 2);
                c = dflt(); c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1;
                push(c, 2);
                add_mem(w, 1'b1);
            end
            4'b1101: begin
                for (int i = 0; i < n0; i++) begin
                    c = dflt(); c.ld_led = (i == 0);
                    push(c, (i == n0 - 1) ? 1 : 0);
                end
                for (int i = 0; i < n1; i++) push(dflt(), (i == n1 - 1) ? 0 : 1);
            end
            default: ;
        endcase
    endtask

    // Called at posedge+1; drives the cycle's inputs, checks at negedge.
    task automatic run_step(input int idx, input step_t s, input string tag);
        logic [3:0] gates;
        cont[idx] = (s.cont == 2) ? 1'($urandom_range(0, 1)) : 1'(s.cont);
        run[idx]  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check(tag, 32'(obs[idx]), 32'(s.c));
        gates = {obs[idx].gate_pc, obs[idx].gate_mdr, obs[idx].gate_alu, obs[idx].gate_marmux};
        check({tag, " gate1hot"}, 32'($countones(gates) <= 1), 32'd1);
        check({tag, " oe_we"}, 32'(obs[idx].oe_n | obs[idx].we_n), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input int idx, input logic [3:0] op, input logic ir5,
                            input logic bn, input int n0, input int n1);
        opcode[idx] = op;
        ir_5[idx]   = ir5;
        ben[idx]    = bn;
        build_instr(wait_of(idx), op, ir5, bn, n0, n1);
        for (int i = 0; i < q.size(); i++)
            run_step(idx, q[i], $sformatf("dut%0d op%h step%0d", idx, op, i));
    endtask

    task automatic reset_start(input int idx);
        rst_n[idx] = 1'b0;
        run[idx]   = 1'b1;
        cont[idx]  = 1'b1;
        #1;
        check($sformatf("dut%0d rst_async", idx), 32'(obs[idx]), 32'(dflt()));
        @(posedge clk);
        #1;
        check($sformatf("dut%0d rst_held", idx), 32'(obs[idx]), 32'(dflt()));
        @(negedge clk);
        rst_n[idx] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_write(input int idx);
        int   w;
        ctl_t c;
        w = wait_of(idx);
        opcode[idx] = 4'b0111;
        build_instr(w, 4'b0111, 1'b0, 1'b0, 1, 1);
        for (int i = 0; i <= q.size() - w; i++)
            run_step(idx, q[i], $sformatf("dut%0d strrst step%0d", idx, i));
        check($sformatf("dut%0d wr2_we", idx), 32'(obs[idx].we_n), 32'd0);
        #2;
        rst_n[idx] = 1'b0;
        #1;
        check($sformatf("dut%0d midwr_we", idx), 32'(obs[idx].we_n), 32'd1);
        check($sformatf("dut%0d midwr_dflt", idx), 32'(obs[idx]), 32'(dflt()));
        run[idx] = 1'b0;
        @(negedge clk);
        rst_n[idx] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cont[idx] = 1'($urandom_range(0, 1));
            check($sformatf("dut%0d halted%0d", idx, i), 32'(obs[idx]), 32'(dflt()));
        end
        run[idx] = 1'b1;
        @(posedge clk);
        #1;
        c = dflt(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1;
        check($sformatf("dut%0d refetch", idx), 32'(obs[idx]), 32'(c));
    endtask

    initial begin
        rst_n  = '{1'b1, 1'b1};
        run    = '{1'b0, 1'b0};
        cont   = '{1'b0, 1'b0};
        opcode = '{4'h0, 4'h0};
        ir_5   = '{1'b0, 1'b0};
        ben    = '{1'b0, 1'b0};
        #2;
        rst_n = '{1'b0, 1'b0};
        for (int idx = 0; idx < 2; idx++) begin
            reset_start(idx);
            do_instr(idx, 4'b0001, 1'b1, 1'b0, 1, 1);
            do_instr(idx, 4'b0101, 1'b0, 1'b1, 1, 1);
            do_instr(idx, 4'b1001, 1'b1, 1'b0, 1, 1);
            do_instr(idx, 4'b0000, 1'b0, 1'b0, 1, 1);
            do_instr(idx, 4'b0000, 1'b1, 1'b1, 1, 1);
            do_instr(idx, 4'b1100, 1'b0, 1'b1, 1, 1);
            do_instr(idx, 4'b0100, 1'b1, 1'b0, 1, 1);
            do_instr(idx, 4'b0110, 1'b0, 1'b0, 1, 1);
            do_instr(idx, 4'b0111, 1'b1, 1'b1, 1, 1);
            do_instr(idx, 4'b1101, 1'b0, 1'b0, 3, 11);
            do_instr(idx, 4'b1101, 1'b0, 1'b0, 1, 1);
            do_instr(idx, 4'b1000, 1'b1, 1'b1, 1, 1);
            for (int k = 0; k < 40; k++)
                do_instr(idx, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4));
            reset_mid_write(idx);
            rst_n[idx] = 1'b0;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
